// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants and helpers for the serial pattern detector
package seq_detect_pkg;

  // Number of bits needed to encode the states S0..S_PAT_W.
  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Index of the empty-prefix state.
  localparam int S_IDLE = 0;

  // Behaviour of the match state on the next accepted bit.
  typedef enum logic {
    OVL_RESTART = 1'b0,
    OVL_OVERLAP = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/seq_detect_next.sv
// rtl/seq_detect_next.sv - combinational next-state / prefix fallback calculator
module seq_detect_next
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  localparam int SW = state_w(PAT_W)
) (
  input  logic [PAT_W-1:0] pattern,
  input  logic [SW-1:0]    state,
  input  logic             x,
  input  logic             overlap,
  output logic [SW-1:0]    next_state
);

  logic [PAT_W:0] cand;
  logic [PAT_W:0] pfx;
  logic [PAT_W:0] mask;
  int             klen;

  // Being in Sk means the recent history equals pattern prefix k, so the
  // candidate string is that prefix with x appended; pick the longest suffix
  // of it that is also a pattern prefix (never longer than the pattern).
  always_comb begin
    next_state = SW'(S_IDLE);
    cand       = '0;
    pfx        = '0;
    mask       = '0;
    klen       = 0;
    if (int'(state) > PAT_W) begin
      next_state = SW'(S_IDLE);
    end else if (int'(state) == PAT_W && overlap == OVL_RESTART) begin
      next_state = (x == pattern[PAT_W-1]) ? SW'(1) : SW'(S_IDLE);
    end else begin
      klen = int'(state) + 1;
      cand = (({1'b0, pattern} >> (PAT_W - int'(state))) << 1) | {{PAT_W{1'b0}}, x};
      for (int j = 1; j <= PAT_W; j++) begin
        pfx  = {1'b0, pattern} >> (PAT_W - j);
        mask = ~({(PAT_W+1){1'b1}} << j);
        if (j <= klen && (cand & mask) == pfx) begin
          next_state = SW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable serial pattern detector, match counter under SEQDET_CNT_EN
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             y,
  output logic [SW-1:0]    state
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

  logic [PAT_W-1:0] pat_q;
  logic [SW-1:0]    nxt;

  seq_detect_next #(
    .PAT_W (PAT_W)
  ) u_next (
    .pattern    (pat_q),
    .state      (state),
    .x          (x),
    .overlap    (overlap),
    .next_state (nxt)
  );

  // Detector state, Moore flag, pattern register and optional match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SW'(S_IDLE);
      y     <= 1'b0;
      pat_q <= PAT_RST;
`ifdef SEQDET_CNT_EN
      match_cnt <= '0;
`endif
    end else if (load) begin
      pat_q <= pat_in;
      state <= SW'(S_IDLE);
      y     <= 1'b0;
`ifdef SEQDET_CNT_EN
      match_cnt <= '0;
`endif
    end else if (state > S_MATCH) begin
      state <= SW'(S_IDLE);
      y     <= 1'b0;
    end else if (x_valid) begin
      state <= nxt;
      y     <= (nxt == S_MATCH);
`ifdef SEQDET_CNT_EN
      if (nxt == S_MATCH && match_cnt != {CNT_W{1'b1}}) begin
        match_cnt <= match_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed bench for seq_detect_param, SEQDET_CNT_EN adds counter checks
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       x;
  logic       x_valid;
  logic       load;
  logic [3:0] pat_in;
  logic       overlap;
  logic       y;
  logic [2:0] state;
`ifdef SEQDET_CNT_EN
  logic [1:0] match_cnt;
`endif

  int errors = 0;
  int checks = 0;

  seq_detect_param #(
    .PAT_W   (4),
    .PAT_RST (4'b1101),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_valid   (x_valid),
    .load      (load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .y         (y),
    .state     (state)
`ifdef SEQDET_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one accepted bit and check the registered state and flag.
  task automatic feed(input string tag, input logic b, input int exp_st);
    x       = b;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_state"}, 32'(state), 32'(exp_st));
    check({tag, "_y"}, 32'(y), (exp_st == 4) ? 32'd1 : 32'd0);
  endtask

  // One cycle with x_valid low and a toggling x that must be ignored.
  task automatic idle(input string tag, input int exp_st);
    x       = ~x;
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_state"}, 32'(state), 32'(exp_st));
    check({tag, "_y"}, 32'(y), (exp_st == 4) ? 32'd1 : 32'd0);
  endtask

  // Load a pattern while also offering a bit that must be dropped.
  task automatic do_load(input string tag, input logic [3:0] p);
    load    = 1'b1;
    pat_in  = p;
    x       = 1'b1;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    rst     = 1'b1;
    x       = 1'b0;
    x_valid = 1'b0;
    load    = 1'b0;
    pat_in  = 4'b0000;
    overlap = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_y", 32'(y), 32'd0);
`ifdef SEQDET_CNT_EN
    check("rst_cnt", 32'(match_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Overlapping matches on 1101101.
    feed("ov_b1", 1'b1, 1);
    feed("ov_b2", 1'b1, 2);
    feed("ov_b3", 1'b0, 3);
    feed("ov_b4", 1'b1, 4);
    feed("ov_b5", 1'b1, 2);
    feed("ov_b6", 1'b0, 3);
    feed("ov_b7", 1'b1, 4);

    // Restart mode on the same stream.
    overlap = 1'b0;
    do_load("ld_a", 4'b1101);
    feed("nr_b1", 1'b1, 1);
    feed("nr_b2", 1'b1, 2);
    feed("nr_b3", 1'b0, 3);
    feed("nr_b4", 1'b1, 4);
    feed("nr_b5", 1'b1, 1);
    feed("nr_b6", 1'b0, 0);
    feed("nr_b7", 1'b1, 1);

    // Fallback from S2 on a 1 stays in S2.
    overlap = 1'b1;
    do_load("ld_b", 4'b1101);
    feed("fb_b1", 1'b1, 1);
    feed("fb_b2", 1'b1, 2);
    feed("fb_b3", 1'b1, 2);
    feed("fb_b4", 1'b0, 3);
    feed("fb_b5", 1'b1, 4);

    // Gap in x_valid holds S3, then idling in the match state holds y.
    do_load("ld_c", 4'b1101);
    feed("gp_b1", 1'b1, 1);
    feed("gp_b2", 1'b1, 2);
    feed("gp_b3", 1'b0, 3);
    idle("gp_i1", 3);
    idle("gp_i2", 3);
    idle("gp_i3", 3);
    feed("gp_b4", 1'b1, 4);
    idle("gp_i4", 4);
    idle("gp_i5", 4);

    // Overlap change takes effect on leaving the match state.
    overlap = 1'b0;
    feed("oc_b1", 1'b1, 1);
    overlap = 1'b1;
    feed("oc_b2", 1'b1, 2);
    feed("oc_b3", 1'b0, 3);

    // Load from S3 with a new pattern, then match it.
    do_load("ld_d", 4'b0110);
    feed("np_b1", 1'b0, 1);
    feed("np_b2", 1'b1, 2);
    feed("np_b3", 1'b1, 3);
    feed("np_b4", 1'b0, 4);
    feed("np_b5", 1'b1, 2);

    // Asynchronous reset mid-match restores S0 and the reset pattern.
    rst = 1'b1;
    #1;
    check("mr_state", 32'(state), 32'd0);
    check("mr_y", 32'(y), 32'd0);
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed("pr_b1", 1'b1, 1);
    feed("pr_b2", 1'b1, 2);
    feed("pr_b3", 1'b0, 3);
    feed("pr_b4", 1'b1, 4);

`ifdef SEQDET_CNT_EN
    // Counter saturates at 3 after five matches and clears on reset.
    check("cnt_m1", 32'(match_cnt), 32'd1);
    for (int m = 0; m < 4; m++) begin
      feed("cs_b1", 1'b1, 2);
      feed("cs_b2", 1'b0, 3);
      feed("cs_b3", 1'b1, 4);
      if (m == 0) check("cnt_m2", 32'(match_cnt), 32'd2);
    end
    check("cnt_sat", 32'(match_cnt), 32'd3);
    feed("cs_b4", 1'b1, 2);
    rst = 1'b1;
    #1;
    check("cnt_rst", 32'(match_cnt), 32'd0);
    check("cnt_rst_state", 32'(state), 32'd0);
    check("cnt_rst_y", 32'(y), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
